// File: rtl/ts_adc_emu_if.sv
// ts_adc_emu_if: D2A control/data inputs and A2D result outputs of the temperature-sensor ADC emulator
interface ts_adc_emu_if;
    logic       D2A_TS_EN;
    logic       D2A_TS_START_EN;
    logic       D2A_TS_CLK;
    logic       D2A_TS_CHOPPER_CLK;
    logic [7:0] temp_code;
    logic [3:0] chop_offset;
    logic       A2D_TS_DETOK;
    logic [7:0] A2D_TS_DOUT;
    logic       busy;
    logic       chop_ph;
    modport master (
        output D2A_TS_EN, D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK, temp_code, chop_offset,
        input  A2D_TS_DETOK, A2D_TS_DOUT, busy, chop_ph
    );
    modport slave (
        input  D2A_TS_EN, D2A_TS_START_EN, D2A_TS_CLK, D2A_TS_CHOPPER_CLK, temp_code, chop_offset,
        output A2D_TS_DETOK, A2D_TS_DOUT, busy, chop_ph
    );
endinterface

// File: rtl/ts_adc_emu.sv
// ts_adc_emu: SAR temperature-sensor ADC emulator with chopper offset; TS_EMU_NOISE_EN adds LFSR dither on bit 0
module ts_adc_emu #(
    parameter int unsigned DETOK_DLY = 2
) (
    input logic        clk,
    input logic        RST,
    ts_adc_emu_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARM, CONV, WAIT, DONE} state_t;
    localparam logic [2:0] LAST = 3'(DETOK_DLY - 1);
    state_t     state, state_nx;
    logic       start_q, tsclk_q, start_rise, tsclk_rise, step, arm_entry;
    logic       detok, chop_ph;
    logic [7:0] dout, sar, target, sat, target_nx, keep, sar_nx;
    logic [2:0] idx, cnt;
    logic [9:0] off_x, sum;
    always_comb begin
        start_rise = bus.D2A_TS_START_EN & ~start_q;
        tsclk_rise = bus.D2A_TS_CLK & ~tsclk_q;
        step       = tsclk_rise & bus.D2A_TS_EN & ~start_rise;
        state_nx   = !bus.D2A_TS_EN ? IDLE :
                     start_rise ? ARM :
                     state == ARM ? CONV :
                     (state == CONV && tsclk_rise && idx == 3'd0) ? WAIT :
                     (state == WAIT && tsclk_rise && cnt == LAST) ? DONE : state;
        arm_entry  = state_nx == ARM;
    end
    // 10-bit signed sum covers -8..263, so bit 9 flags underflow and bit 8 overflow
    always_comb begin
        off_x = {{6{bus.chop_offset[3]}}, bus.chop_offset};
        sum   = bus.D2A_TS_CHOPPER_CLK ? {2'b00, bus.temp_code} + off_x : {2'b00, bus.temp_code} - off_x;
        sat   = sum[9] ? 8'h00 : sum[8] ? 8'hFF : sum[7:0];
    end
`ifdef TS_EMU_NOISE_EN
    logic [7:0] lfsr, lfsr_nx;
    always_comb begin
        lfsr_nx   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        target_nx = {sat[7:1], sat[0] ^ lfsr_nx[0]};
    end
    always_ff @(posedge clk)
        if (RST) lfsr <= 8'hA5;
        else if (arm_entry) lfsr <= lfsr_nx;
`else
    always_comb target_nx = sat;
`endif
    always_comb begin
        keep   = sar <= target ? sar : sar & ~(8'h01 << idx);
        sar_nx = keep | (idx == 3'd0 ? 8'h00 : 8'h01 << (idx - 3'd1));
    end
    always_ff @(posedge clk) begin
        if (RST) begin
            state   <= IDLE;
            start_q <= 1'b0;
            tsclk_q <= 1'b0;
            detok   <= 1'b0;
            dout    <= 8'h70;
            chop_ph <= 1'b0;
            target  <= 8'h00;
            sar     <= 8'h00;
            idx     <= 3'd0;
            cnt     <= 3'd0;
        end else begin
            state   <= state_nx;
            start_q <= bus.D2A_TS_START_EN;
            tsclk_q <= bus.D2A_TS_CLK;
            detok   <= state == DONE && state_nx == DONE;
            if (arm_entry) begin
                chop_ph <= bus.D2A_TS_CHOPPER_CLK;
                target  <= target_nx;
                sar     <= 8'h80;
                idx     <= 3'd7;
                cnt     <= 3'd0;
            end else if (state == CONV && step) begin
                sar <= sar_nx;
                idx <= idx - 3'd1;
            end else if (state == WAIT && step) begin
                cnt <= cnt + 3'd1;
            end
            if (state == WAIT && state_nx == DONE) dout <= sar;
        end
    end
    assign bus.A2D_TS_DETOK = detok;
    assign bus.A2D_TS_DOUT  = dout;
    assign bus.busy         = state == ARM || state == CONV || state == WAIT;
    assign bus.chop_ph      = chop_ph;
endmodule
